// File: rtl/mt_pkg.sv
// Shared constants, default geometry and FSM state type for the MT19937 RAM-backed engine.
package mt_pkg;

  localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
  localparam logic [31:0] TEMPER_B   = 32'h9D2C_5680;
  localparam logic [31:0] TEMPER_C   = 32'hEFC6_0000;
  localparam logic [31:0] INIT_MULT  = 32'd1812433253;

  localparam int DEFAULT_N = 624;
  localparam int DEFAULT_M = 397;

  typedef enum logic [2:0] {
    ST_UNSEEDED,
    ST_INIT,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_WR,
    ST_OUT
  } mt_state_e;

endpackage

// File: rtl/mt_temper.sv
// Combinational MT19937 output tempering.
module mt_temper
  import mt_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] tempered
);

  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] t3;

  assign t1       = word ^ (word >> 11);
  assign t2       = t1 ^ ((t1 << 7) & TEMPER_B);
  assign t3       = t2 ^ ((t2 << 15) & TEMPER_C);
  assign tempered = t3 ^ (t3 >> 18);

endmodule

// File: rtl/mt_ram_ctrl.sv
// MT19937 engine holding its state table in an external single-port RAM.
// Seeds the table, twists one word in place per draw and streams tempered output.
//
//   state    | meaning
//   UNSEEDED | after reset, waiting for a seed; no RAM access
//   INIT     | writing seed-expanded word k to addr k, one per cycle
//   RD0      | read x[i]
//   RD1      | read x[i+1]; capture x[i]
//   RD2      | read x[i+M]; capture x[i+1]
//   WR       | x[i+M] on ram_dout; write twisted word, register tempered output
//   OUT      | rand_valid held until accepted, then advance i
module mt_ram_ctrl
  import mt_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int N          = DEFAULT_N,
  parameter int M          = DEFAULT_M
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_valid,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  rand_valid,
  input  logic                  rand_ready,
  output logic [31:0]           rand_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   M_EXT    = (ADDR_WIDTH + 1)'(M);
  localparam logic [ADDR_WIDTH:0]   N_EXT    = (ADDR_WIDTH + 1)'(N);

  mt_state_e             state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           x_init;
  logic [31:0]           x_i;
  logic [31:0]           x_i1;

  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [ADDR_WIDTH:0]   sum_m;
  logic [ADDR_WIDTH-1:0] idx_m;
  logic [31:0]           init_next;
  logic [31:0]           y;
  logic [31:0]           twisted;
  logic [31:0]           tempered;

  always_comb begin
    idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    sum_m   = {1'b0, idx} + M_EXT;
    idx_m   = (sum_m >= N_EXT) ? ADDR_WIDTH'(sum_m - N_EXT) : sum_m[ADDR_WIDTH-1:0];
  end

  // x_init holds x[k] while it is written; the next word uses index k+1.
  assign init_next = INIT_MULT * (x_init ^ (x_init >> 30)) + 32'(idx) + 32'd1;

  assign y       = (x_i & UPPER_MASK) | (x_i1 & LOWER_MASK);
  assign twisted = ram_dout ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'h0);

  mt_temper u_temper (
    .word     (twisted),
    .tempered (tempered)
  );

  // A seed load in the same cycle cancels whatever access the current state wanted.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!seed_valid) begin
      case (state)
        ST_INIT: begin
          ram_cs   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = idx;
          ram_din  = x_init;
        end
        ST_RD0: begin
          ram_cs   = 1'b1;
          ram_oe   = 1'b1;
          ram_addr = idx;
        end
        ST_RD1: begin
          ram_cs   = 1'b1;
          ram_oe   = 1'b1;
          ram_addr = idx_inc;
        end
        ST_RD2: begin
          ram_cs   = 1'b1;
          ram_oe   = 1'b1;
          ram_addr = idx_m;
        end
        ST_WR: begin
          ram_cs   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = idx;
          ram_din  = twisted;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_UNSEEDED;
      idx        <= '0;
      x_init     <= '0;
      x_i        <= '0;
      x_i1       <= '0;
      rand_data  <= '0;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (seed_valid) begin
      state      <= ST_INIT;
      idx        <= '0;
      x_init     <= seed;
      rand_valid <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          x_init <= init_next;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_RD0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_RD0: state <= ST_RD1;
        ST_RD1: begin
          x_i   <= ram_dout;
          state <= ST_RD2;
        end
        ST_RD2: begin
          x_i1  <= ram_dout;
          state <= ST_WR;
        end
        ST_WR: begin
          rand_data  <= tempered;
          rand_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (rand_ready) begin
            rand_valid <= 1'b0;
            busy       <= 1'b1;
            idx        <= idx_inc;
            state      <= ST_RD0;
          end
        end
        default: state <= ST_UNSEEDED;
      endcase
    end
  end

endmodule

// File: tb/tb_mt_ram_ctrl.sv
// Self-checking bench for mt_ram_ctrl with a behavioural RAM and a block-twist MT19937 model.
module tb_mt_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = '0;
  logic        busy;
  logic        rand_valid;
  logic        rand_ready = 1'b0;
  logic [31:0] rand_data;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;

  logic [31:0] mem [0:1023];

  int errors = 0;
  int checks = 0;
  int stable_bad = 0;

  always #5 clk = ~clk;

  mt_ram_ctrl #(.ADDR_WIDTH(10), .N(624), .M(397)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .busy       (busy),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .rand_data  (rand_data),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
    if (ram_cs && ram_oe) ram_dout <= mem[ram_addr];
  end

  // Reference MT19937: whole-table twist every 624 draws.
  bit [31:0] mdl_mt [624];
  int        mdl_idx;

  function automatic bit [31:0] ref_temper(input bit [31:0] v);
    bit [31:0] z;
    z = v;
    z = z ^ (z >> 11);
    z = z ^ ((z << 7) & 32'h9D2C_5680);
    z = z ^ ((z << 15) & 32'hEFC6_0000);
    z = z ^ (z >> 18);
    return z;
  endfunction

  task automatic mdl_seed(input bit [31:0] s);
    mdl_mt[0] = s;
    for (int k = 1; k < 624; k++)
      mdl_mt[k] = 32'd1812433253 * (mdl_mt[k-1] ^ (mdl_mt[k-1] >> 30)) + 32'(k);
    mdl_idx = 624;
  endtask

  task automatic mdl_next(output bit [31:0] r);
    bit [31:0] yv;
    if (mdl_idx >= 624) begin
      for (int k = 0; k < 624; k++) begin
        yv = (mdl_mt[k] & 32'h8000_0000) | (mdl_mt[(k + 1) % 624] & 32'h7FFF_FFFF);
        mdl_mt[k] = mdl_mt[(k + 397) % 624] ^ (yv >> 1) ^ (yv[0] ? 32'h9908_B0DF : 32'h0);
      end
      mdl_idx = 0;
    end
    r = ref_temper(mdl_mt[mdl_idx]);
    mdl_idx++;
  endtask

  task automatic do_seed(input logic [31:0] s);
    @(negedge clk);
    seed_valid = 1'b1;
    seed = s;
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  // Waits for one accepted word; ready is randomised per cycle with probability pct.
  task automatic get_word(input int pct, output logic [31:0] w);
    bit          held;
    logic [31:0] hold_val;
    held = 0;
    hold_val = '0;
    w = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rand_ready = ($urandom_range(0, 99) < pct);
      #1;
      if (rand_valid) begin
        if (held && rand_data !== hold_val) stable_bad++;
        if (rand_ready) begin
          w = rand_data;
          return;
        end
        held = 1;
        hold_val = rand_data;
      end
    end
    checks++;
    errors++;
    $display("FAIL get_word_timeout: no accepted word within 3000 cycles");
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, rand_valid, ram_cs, ram_we, ram_oe} !== 5'b0 || rand_data !== 32'h0 ||
        ram_addr !== 10'h0 || ram_din !== 32'h0)
      begin errors++; $display("FAIL reset_outputs: busy=%b valid=%b cs=%b we=%b oe=%b data=%h addr=%h din=%h, required all 0",
                               busy, rand_valid, ram_cs, ram_we, ram_oe, rand_data, ram_addr, ram_din); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (ram_cs || busy || rand_valid) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL unseeded_idle: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_init_trace();
    int bad;
    mdl_seed(32'd5489);
    do_seed(32'd5489);
    bad = 0;
    for (int k = 0; k < 624; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (!(ram_cs && ram_we && !ram_oe && busy && !rand_valid && ram_addr == 10'(k) && ram_din == mdl_mt[k]))
        bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_writes: %0d bad INIT cycles of 624, required 0", bad); end
    @(negedge clk);
    #1;
    checks++;
    if (!(ram_cs && ram_oe && !ram_we && ram_addr == 10'd0 && busy))
      begin errors++; $display("FAIL init_end_rd0: cs=%b oe=%b we=%b addr=%0d, required read of addr 0", ram_cs, ram_oe, ram_we, ram_addr); end
    checks++;
    if (mem[0] !== 32'd5489) begin errors++; $display("FAIL ram0_seed: got %0d required 5489", mem[0]); end
    checks++;
    if (mem[623] !== mdl_mt[623]) begin errors++; $display("FAIL ram623: got %h required %h", mem[623], mdl_mt[623]); end
  endtask

  task automatic test_known();
    logic [31:0] w;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'd3499211612;
    exp_w[1] = 32'd581869302;
    exp_w[2] = 32'd3890346734;
    for (int n = 0; n < 3; n++) begin
      get_word(100, w);
      checks++;
      if (w !== exp_w[n]) begin errors++; $display("FAIL known_word%0d: got %0d required %0d", n, w, exp_w[n]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    logic [31:0] m;
    logic [31:0] hold;
    int bad;
    int n;
    mdl_seed(32'd5489);
    do_seed(32'd5489);
    get_word(100, w);
    mdl_next(m);
    checks++;
    if (w !== m) begin errors++; $display("FAIL stall_first: got %h required %h", w, m); end
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      rand_ready = 1'b0;
      #1;
      if (rand_valid) break;
    end
    checks++;
    if (!rand_valid) begin errors++; $display("FAIL stall_wait_valid: rand_valid=%b required 1", rand_valid); end
    hold = rand_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (rand_data !== hold || !rand_valid || ram_cs || busy) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d bad stalled cycles, required 0", bad); end
    mdl_next(m);
    checks++;
    if (hold !== m) begin errors++; $display("FAIL stall_word: got %h required %h", hold, m); end
    get_word(100, w);
    bad = 0;
    if (w !== hold) bad++;
    for (int k = 0; k < 3; k++) begin
      get_word(100, w);
      mdl_next(m);
      if (w !== m) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_after: %0d wrong words after stall, required 0", bad); end
  endtask

  task automatic test_reseed();
    logic [31:0] w;
    logic [31:0] pre;
    logic [9:0]  wa;
    bit          found;
    do_seed(32'd5489);
    get_word(100, w);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (ram_cs && ram_we) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reseed_find_wr: no write seen, required WR of 2nd draw"); end
    wa = ram_addr;
    pre = mem[wa];
    seed_valid = 1'b1;
    seed = 32'd5489;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_cs !== 1'b0)
      begin errors++; $display("FAIL reseed_suppress: cs=%b we=%b required 0 0", ram_cs, ram_we); end
    @(negedge clk);
    seed_valid = 1'b0;
    #1;
    checks++;
    if (mem[wa] !== pre) begin errors++; $display("FAIL reseed_ram_untouched: addr %0d got %h required %h", wa, mem[wa], pre); end
    checks++;
    if (rand_valid !== 1'b0 || busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'd0)
      begin errors++; $display("FAIL reseed_init: valid=%b busy=%b we=%b addr=%0d required 0 1 1 0", rand_valid, busy, ram_we, ram_addr); end
    get_word(100, w);
    checks++;
    if (w !== 32'd3499211612) begin errors++; $display("FAIL reseed_word: got %0d required 3499211612", w); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [31:0] m;
    logic [31:0] s;
    int bad;
    for (int r = 0; r < 3; r++) begin
      s = $urandom;
      mdl_seed(s);
      do_seed(s);
      bad = 0;
      stable_bad = 0;
      for (int n = 0; n < 30; n++) begin
        get_word(60, w);
        mdl_next(m);
        if (w !== m) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL random_seed_%0d: seed %h, %0d wrong words of 30, required 0", r, s, bad); end
      checks++;
      if (stable_bad != 0) begin errors++; $display("FAIL random_stable_%0d: %0d unstable held cycles, required 0", r, stable_bad); end
    end
  endtask

  task automatic test_reset_mid_init();
    logic [31:0] s;
    logic [31:0] w;
    logic [31:0] m;
    int bad;
    s = $urandom;
    do_seed(s);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rand_valid, ram_cs, ram_we, ram_oe} !== 5'b0 || rand_data !== 32'h0 ||
        ram_addr !== 10'h0 || ram_din !== 32'h0)
      begin errors++; $display("FAIL midinit_reset_outputs: busy=%b valid=%b cs=%b we=%b oe=%b data=%h, required all 0",
                               busy, rand_valid, ram_cs, ram_we, ram_oe, rand_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (ram_cs || ram_we || ram_oe || busy || rand_valid || rand_data != 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midinit_idle: %0d active cycles after release, required 0", bad); end
    mdl_seed(s);
    do_seed(s);
    get_word(100, w);
    mdl_next(m);
    checks++;
    if (w !== m) begin errors++; $display("FAIL midinit_recover: got %h required %h", w, m); end
  endtask

  task automatic test_long();
    logic [31:0] w;
    logic [31:0] m;
    int bad;
    mdl_seed(32'd5489);
    do_seed(32'd5489);
    bad = 0;
    w = '0;
    for (int n = 0; n < 10000; n++) begin
      get_word(100, w);
      mdl_next(m);
      if (w !== m) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL long_model: %0d wrong words of 10000, required 0", bad); end
    checks++;
    if (w !== 32'd4123659995) begin errors++; $display("FAIL long_word10000: got %0d required 4123659995", w); end
  endtask

  initial begin
    test_reset();
    test_init_trace();
    test_known();
    test_stall();
    test_reseed();
    test_random();
    test_reset_mid_init();
    test_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
